// File: rtl/arb_stream_buffer.sv
// Elastic 32-bit stream stage between the readout arbiter and the SRAM FIFO
// write side. A small buffer absorbs bursts, the SRAM near-full flag throttles
// every push, and timestamp marker words are periodically slipped into the
// stream so software can re-align after overflow. The head word sits in a
// registered output stage (first-word-fall-through), so a word pushed into an
// empty buffer shows up on OUT_DATA one edge after it was written.
module arb_stream_buffer #(
    parameter int         DEPTH         = 16,
    parameter int         MARKER_PERIOD = 1048576,
    parameter logic [3:0] MARKER_HEADER = 4'hF
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic                     ENABLE,
    input  logic                     MARKER_EN,
    input  logic                     IN_WRITE,
    input  logic [31:0]              IN_DATA,
    output logic                     IN_READY,
    input  logic                     FIFO_NEAR_FULL,
    output logic                     OUT_EMPTY,
    output logic [31:0]              OUT_DATA,
    input  logic                     OUT_READ_NEXT,
    output logic [$clog2(DEPTH):0]   FILL_LEVEL,
    output logic [31:0]              WORD_COUNT,
    output logic [15:0]              MARKER_COUNT,
    output logic [15:0]              MARKER_LOST
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(MARKER_PERIOD);
    localparam logic [TW-1:0] TMAX  = TW'(MARKER_PERIOD - 1);
    localparam logic [CW-1:0] CDEPTH = CW'(DEPTH);

    // Storage behind the output stage; the head word lives in out_data_q.
    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d;   // words in mem_q only
    logic [CW-1:0] fill_q, fill_d;         // words in mem_q plus output stage
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;
    logic [27:0]   ts_q, ts_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;
    logic [31:0]   word_cnt_q, word_cnt_d;
    logic [15:0]   marker_cnt_q, marker_cnt_d;
    logic [15:0]   lost_q, lost_d;

    logic          can_push;
    logic          marker_push;
    logic          in_push;
    logic          push;
    logic [31:0]   push_data;
    logic          pop;
    logic          load;
    logic          timer_run;
    logic          timer_hit;
    logic          lost_inc;

    // Handshake: upstream word transfers when IN_WRITE and IN_READY are both
    // high at a rising edge; the SRAM side pops when OUT_READ_NEXT is high
    // while OUT_EMPTY is low. Push permission comes only from registered
    // state, so a pop in the same cycle never frees room for a push.
    always_comb begin
        can_push    = ENABLE & ~FIFO_NEAR_FULL & (fill_q < CDEPTH);
        marker_push = pending_q & can_push;
        in_push     = IN_WRITE & can_push & ~pending_q & ~BUS_RST;
        push        = marker_push | in_push;
        push_data   = marker_push ? {MARKER_HEADER, ts_q} : IN_DATA;
        pop         = OUT_READ_NEXT & out_valid_q;
        load        = (mem_cnt_q != '0) & (~out_valid_q | pop);
        IN_READY    = can_push & ~pending_q & ~BUS_RST;
        OUT_EMPTY   = ~out_valid_q;
        OUT_DATA    = out_data_q;
        FILL_LEVEL  = fill_q;
        WORD_COUNT  = word_cnt_q;
        MARKER_COUNT = marker_cnt_q;
        MARKER_LOST = lost_q;
    end

    // Next-state for pointers, occupancy, output stage, timer and counters.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        word_cnt_d   = word_cnt_q;
        marker_cnt_d = marker_cnt_q;
        lost_d       = lost_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (load) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_data_d  = mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
        mem_cnt_d = mem_cnt_q + CW'(push) - CW'(load);
        fill_d    = fill_q + CW'(push) - CW'(pop);

        ts_d = ts_q + 28'd1;

        // The timer only runs while markers are wanted; a request that finds
        // an earlier marker still waiting (and not leaving this cycle) is lost.
        timer_run = ENABLE & MARKER_EN;
        timer_hit = timer_run & (timer_q == TMAX);
        timer_d   = (timer_run & ~timer_hit) ? timer_q + 1'b1 : '0;
        lost_inc  = timer_hit & pending_q & ~marker_push;
        pending_d = timer_hit | (pending_q & ~marker_push);

        if (in_push) begin
            word_cnt_d = word_cnt_q + 32'd1;
        end
        if (marker_push) begin
            marker_cnt_d = marker_cnt_q + 16'd1;
        end
        if (lost_inc && (lost_q != 16'hFFFF)) begin
            lost_d = lost_q + 16'd1;
        end
    end

    // State registers; reset discards buffered words and clears all counters.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            fill_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            ts_q         <= '0;
            timer_q      <= '0;
            pending_q    <= 1'b0;
            word_cnt_q   <= '0;
            marker_cnt_q <= '0;
            lost_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_cnt_q    <= mem_cnt_d;
            fill_q       <= fill_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            ts_q         <= ts_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            word_cnt_q   <= word_cnt_d;
            marker_cnt_q <= marker_cnt_d;
            lost_q       <= lost_d;
        end
    end

    // Buffer RAM write port; contents need no reset since occupancy gates reads.
    always_ff @(posedge BUS_CLK) begin
        if (push && !BUS_RST) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_arb_stream_buffer.sv
// Bench for arb_stream_buffer: a cycle-level reference model derived from the
// stream rules pushes every expected output word into exp_q; an independent
// monitor pops and compares whenever the DUT hands a word to the SRAM side.
module tb_arb_stream_buffer;

  localparam int DEPTH  = 16;
  localparam int PERIOD = 8;

  logic        clk = 1'b0;
  logic        rst, en, men, wr, nf, rd;
  logic [31:0] din;
  logic        in_ready, out_empty;
  logic [31:0] out_data, word_count;
  logic [4:0]  fill_level;
  logic [15:0] marker_count, marker_lost;

  // clock / reset block
  always #5 clk = ~clk;

  arb_stream_buffer #(
    .DEPTH(DEPTH),
    .MARKER_PERIOD(PERIOD),
    .MARKER_HEADER(4'hF)
  ) dut (
    .BUS_CLK(clk),
    .BUS_RST(rst),
    .ENABLE(en),
    .MARKER_EN(men),
    .IN_WRITE(wr),
    .IN_DATA(din),
    .IN_READY(in_ready),
    .FIFO_NEAR_FULL(nf),
    .OUT_EMPTY(out_empty),
    .OUT_DATA(out_data),
    .OUT_READ_NEXT(rd),
    .FILL_LEVEL(fill_level),
    .WORD_COUNT(word_count),
    .MARKER_COUNT(marker_count),
    .MARKER_LOST(marker_lost)
  );

  // reference model state
  int          m_fill, m_timer, m_lost, cyc, last_pop;
  bit          m_pending, m_just_reset, mon_on;
  logic [31:0] m_words;
  logic [15:0] m_markers;
  logic [27:0] m_ts;
  int          vis_q[$];          // edge at which each buffered word was pushed
  logic [31:0] exp_q[$];          // scoreboard: expected output stream
  int          errors, checks;

  // A word pushed at edge E is visible from edge E+1, but never before the
  // edge that popped its predecessor.
  function automatic bit m_visible();
    int t;
    if (vis_q.size() == 0) return 1'b0;
    t = vis_q[0] + 1;
    if (last_pop > t) t = last_pop;
    return cyc >= t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: advance one edge and update the model with the inputs just applied
  task automatic tick();
    bit can, mp, ip, pp, req;
    int e;
    @(posedge clk);
    #1;
    e = cyc + 1;
    if (rst) begin
      m_fill = 0; m_timer = 0; m_lost = 0; m_pending = 1'b0;
      m_words = '0; m_markers = '0; m_ts = '0;
      vis_q.delete(); exp_q.delete();
      last_pop = e;
      m_just_reset = 1'b1;
    end else begin
      m_just_reset = 1'b0;
      can = en && !nf && (m_fill < DEPTH);
      mp  = m_pending && can;
      ip  = wr && can && !m_pending;
      pp  = rd && m_visible();
      req = en && men && (m_timer == PERIOD - 1);
      m_timer = (en && men) ? (m_timer + 1) % PERIOD : 0;
      if (mp) begin
        exp_q.push_back({4'hF, m_ts});
        vis_q.push_back(e);
        m_markers++;
      end
      if (ip) begin
        exp_q.push_back(din);
        vis_q.push_back(e);
        m_words++;
      end
      if (req && m_pending && !mp && m_lost < 16'hFFFF) m_lost++;
      m_pending = req || (m_pending && !mp);
      if (pp) begin
        void'(vis_q.pop_front());
        last_pop = e;
      end
      m_fill = m_fill + int'(mp || ip) - int'(pp);
      m_ts++;
    end
    cyc = e;
  endtask

  // monitor: compare status every cycle, pop scoreboard on each handed-off word
  always @(negedge clk) begin
    if (mon_on) begin
      chk("in_ready", 32'(in_ready), 32'(!rst && en && !nf && (m_fill < DEPTH) && !m_pending));
      chk("out_empty", 32'(out_empty), 32'(!m_visible()));
      chk("fill_level", 32'(fill_level), 32'(m_fill));
      chk("word_count", word_count, m_words);
      chk("marker_count", 32'(marker_count), 32'(m_markers));
      chk("marker_lost", 32'(marker_lost), 32'(m_lost));
      if (m_just_reset) chk("out_data_after_reset", out_data, 32'h0);
      if (!out_empty && rd && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data: got 0x%08h expected no word (edge %0d)", out_data, cyc);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    errors = 0; checks = 0; cyc = 0; last_pop = 0; mon_on = 1'b0;
    rst = 1'b1; en = 1'b0; men = 1'b0; wr = 1'b0; nf = 1'b0; rd = 1'b0; din = '0;
    tick();
    mon_on = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // back-to-back words 1..5 with continuous reads
    en = 1'b1; rd = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr = 1'b1; din = 32'(i);
      tick();
    end
    wr = 1'b0;
    repeat (5) tick();

    // fill to DEPTH with no reads, one pop re-opens, then drain
    rd = 1'b0; wr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = $urandom;
      tick();
    end
    rd = 1'b1; tick();
    rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = $urandom;
      tick();
    end
    wr = 1'b0; rd = 1'b1;
    repeat (20) tick();

    // idle input with markers enabled
    men = 1'b1;
    repeat (40) tick();

    // near-full hold with a waiting input word, then release
    nf = 1'b1; wr = 1'b1; din = $urandom;
    repeat (30) tick();
    nf = 1'b0;
    repeat (10) tick();
    wr = 1'b0;
    repeat (10) tick();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      nf  = ($urandom_range(0, 4) == 0);
      wr  = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 9) < 6);
      men = ($urandom_range(0, 19) != 0);
      din = $urandom;
      if ($urandom_range(0, 7) == 0) din[31:28] = 4'hF;
      tick();
    end
    en = 1'b1; nf = 1'b0; wr = 1'b0; rd = 1'b1; men = 1'b0;
    repeat (30) tick();

    // reset with ten words buffered, then reads while empty
    rd = 1'b0; wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = $urandom;
      tick();
    end
    rst = 1'b1; wr = 1'b0;
    tick();
    rst = 1'b0; rd = 1'b1;
    repeat (5) tick();

    // ENABLE low with three words buffered: they still drain
    rd = 1'b0; wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = $urandom;
      tick();
    end
    en = 1'b0; men = 1'b1;
    repeat (3) tick();
    rd = 1'b1;
    repeat (6) tick();
    en = 1'b1; wr = 1'b0;
    repeat (20) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d words left expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_stream_buffer.md
Name: arb_stream_buffer

Overview:
- Elastic 32-bit stream stage between the readout arbiter output and the SRAM FIFO write side of the MIO top level, all in BUS_CLK.
- Absorbs arbiter bursts in a small first-word-fall-through buffer and applies back-pressure from the SRAM FIFO near-full flag.
- Periodically inserts timestamp marker words into the stream so software can re-align data after overflow or throttling.
- Keeps word, marker and lost-marker counters for status readout.

Parameters:
DEPTH, 16, buffer depth in 32-bit words; power of two, 4..256
MARKER_PERIOD, 1048576, BUS_CLK cycles between marker requests; at least 2
MARKER_HEADER, 4'hF, bits [31:28] of every marker word

Ports:
BUS_CLK  input  1  sole clock
BUS_RST  input  1  synchronous reset, active-high
ENABLE  input  1  1 = accept input and generate markers; 0 = IN_READY low, marker timer held at 0
MARKER_EN  input  1  1 = marker insertion enabled
IN_WRITE  input  1  upstream word valid
IN_DATA  input  32  upstream word
IN_READY  output  1  buffer accepts IN_DATA this cycle
FIFO_NEAR_FULL  input  1  SRAM FIFO near-full; throttles all pushes
OUT_EMPTY  output  1  no word available on OUT_DATA
OUT_DATA  output  32  head word (FWFT, valid while OUT_EMPTY=0)
OUT_READ_NEXT  input  1  SRAM FIFO pops the head word
FILL_LEVEL  output  log2(DEPTH)+1  words currently held
WORD_COUNT  output  32  input words accepted, wraps at 2^32
MARKER_COUNT  output  16  markers inserted, wraps
MARKER_LOST  output  16  marker requests dropped, saturates at 16'hFFFF

Behaviour:
- Reset (BUS_RST=1 at an edge):
  - Clears pointers, FILL_LEVEL, all counters, the timestamp, the marker timer and the pending flag.
  - Outputs: OUT_EMPTY=1, OUT_DATA=0, IN_READY=0 during reset, then registered per the rules below.
  - Reset mid-burst discards buffer contents; no partial word is emitted.
- Timestamp: ts[27:0] increments every cycle when not in reset and wraps freely.
- Marker timer:
  - Counts 0..MARKER_PERIOD-1 while ENABLE=1 and MARKER_EN=1, otherwise held at 0.
  - On reaching MARKER_PERIOD-1 it sets marker_pending.
  - If marker_pending is already set, MARKER_LOST increments instead and marker_pending stays at 1.
- Push permission: can_push = ENABLE & !FIFO_NEAR_FULL & (FILL_LEVEL < DEPTH), all from registered state.
  - A pop in the same cycle does not free space for a push.
- Marker priority:
  - If marker_pending & can_push, the marker {MARKER_HEADER, ts[27:0]} is pushed, marker_pending clears and MARKER_COUNT increments.
  - In that cycle IN_READY=0.
- IN_READY = can_push & !marker_pending.
  - A transfer occurs when IN_WRITE & IN_READY; IN_DATA is pushed and WORD_COUNT increments.
  - IN_DATA is not required to be stable while IN_READY=0.
- Latency:
  - A word pushed at edge N is visible on OUT_DATA with OUT_EMPTY=0 after edge N+1 when the buffer was empty.
  - Otherwise it follows all older words.
- Pop: OUT_READ_NEXT with OUT_EMPTY=0 advances the head; the next word appears the following cycle. OUT_READ_NEXT while OUT_EMPTY=1 is ignored, with no state change.
- Simultaneous push and pop leaves FILL_LEVEL unchanged. Read and write pointers wrap modulo DEPTH.
- Order is preserved strictly. Markers appear between input words exactly in push order.
- Input words whose bits [31:28] equal MARKER_HEADER pass unmodified. Header uniqueness is an upstream responsibility.
- ENABLE falling to 0 stops pushes but drains normally. Pending markers stay pending until re-enabled.
- FIFO_NEAR_FULL=1 stops all pushes, including markers. Popping continues.

Test Plan:
- Reset, then ENABLE=1, MARKER_EN=0, 5 words 0x1..0x5 back-to-back with OUT_READ_NEXT=1 -> OUT_DATA shows 0x1..0x5 in order, first one cycle after push; WORD_COUNT=5; OUT_EMPTY=1 at end.
- OUT_READ_NEXT=0, continuous IN_WRITE -> exactly DEPTH=16 words accepted; IN_READY=0 at FILL_LEVEL=16; one pop re-opens IN_READY the cycle after; no word lost or duplicated.
- MARKER_PERIOD=8, MARKER_EN=1, idle input -> marker every 8 cycles with [31:28]=4'hF; consecutive ts fields differ by 8; MARKER_COUNT increments per marker.
- MARKER_PERIOD=8, FIFO_NEAR_FULL=1 for 30 cycles -> 1 marker pending, MARKER_LOST=2 or 3 depending on phase; after release, exactly 1 marker is pushed, ahead of the waiting input word.
- Assert BUS_RST mid-burst with 10 words buffered -> next cycle OUT_EMPTY=1, FILL_LEVEL=0, counters 0; OUT_READ_NEXT pulses while empty cause no change.
- ENABLE=0 with 3 words buffered -> IN_READY=0, 3 words still drain, marker timer stays 0.
